// File: rtl/ex_muldiv_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_muldiv_pkg
// Description : Shared op codes, FSM encoding and helpers for the EX mul/div unit.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_muldiv_pkg;

    localparam int MULDIV_ITER = 32;

    typedef logic [3:0] op_code_t;

    localparam op_code_t OP_NOP   = 4'd0;
    localparam op_code_t OP_MULT  = 4'd1;
    localparam op_code_t OP_MULTU = 4'd2;
    localparam op_code_t OP_DIV   = 4'd3;
    localparam op_code_t OP_DIVU  = 4'd4;
    localparam op_code_t OP_MFHI  = 4'd5;
    localparam op_code_t OP_MFLO  = 4'd6;
    localparam op_code_t OP_MTHI  = 4'd7;
    localparam op_code_t OP_MTLO  = 4'd8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    function automatic logic is_muldiv(input op_code_t op);
        return (op >= OP_MULT) && (op <= OP_DIVU);
    endfunction

    // Every op that touches HI/LO must wait for an in-flight mul/div.
    function automatic logic is_hilo_op(input op_code_t op);
        return (op >= OP_MULT) && (op <= OP_MTLO);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ex_muldiv_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : ex_muldiv_unit_if
// Description : Issue/result bundle between the ID/EX stage and the mul/div unit.
// Revision    : 1.0 - initial release
// ============================================================================
interface ex_muldiv_unit_if
    import mips_muldiv_pkg::*;
#(
    parameter int WIDTH = MULDIV_ITER
);
    logic             op_valid;
    op_code_t         op_code;
    logic [WIDTH-1:0] source_a_data;
    logic [WIDTH-1:0] source_b_data;
    logic [WIDTH-1:0] hi_lo_data;
    logic             busy;
    logic             stall;
    logic             done;

    modport master (
        output op_valid, op_code, source_a_data, source_b_data,
        input  hi_lo_data, busy, stall, done
    );

    modport slave (
        input  op_valid, op_code, source_a_data, source_b_data,
        output hi_lo_data, busy, stall, done
    );
endinterface
`default_nettype wire

// File: rtl/ex_muldiv_unit_iter_core.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_iter_core
// Description : Unsigned 2*WIDTH accumulator; one shift-add or restoring
//               shift-subtract step per enabled edge.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_iter_core #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic             mode_div,
    input  logic [WIDTH-1:0] mag_a,
    input  logic [WIDTH-1:0] mag_b,
    output logic [WIDTH-1:0] acc_hi,
    output logic [WIDTH-1:0] acc_lo
);
    logic [WIDTH-1:0] r_hi, r_lo, r_b;
    logic [WIDTH-1:0] w_hi_next, w_lo_next, w_diff;
    logic [WIDTH:0]   w_sum, w_shift;
    logic             w_ge;

    // Remainder stays below the divisor, so the low WIDTH bits of the
    // difference are exact whenever the subtract is taken.
    always_comb begin
        w_sum     = {1'b0, r_hi} + {1'b0, r_b};
        w_shift   = {r_hi, r_lo[WIDTH-1]};
        w_ge      = (w_shift >= {1'b0, r_b});
        w_diff    = w_shift[WIDTH-1:0] - r_b;
        w_hi_next = r_hi;
        w_lo_next = r_lo;
        if (mode_div) begin
            w_hi_next = w_ge ? w_diff : w_shift[WIDTH-1:0];
            w_lo_next = {r_lo[WIDTH-2:0], w_ge};
        end else if (r_lo[0]) begin
            {w_hi_next, w_lo_next} = {w_sum, r_lo[WIDTH-1:1]};
        end else begin
            {w_hi_next, w_lo_next} = {1'b0, r_hi, r_lo[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_hi <= '0;
            r_lo <= '0;
            r_b  <= '0;
        end else if (load) begin
            r_hi <= '0;
            r_lo <= mag_a;
            r_b  <= mag_b;
        end else if (step) begin
            r_hi <= w_hi_next;
            r_lo <= w_lo_next;
        end
    end

    assign acc_hi = r_hi;
    assign acc_lo = r_lo;
endmodule
`default_nettype wire

// File: rtl/ex_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : ex_muldiv_unit
// Description : EX-stage iterative MULT/MULTU/DIV/DIVU with HI/LO registers,
//               MFHI/MFLO/MTHI/MTLO and hazard stall generation.
// Revision    : 1.0 - initial release
// ============================================================================
module ex_muldiv_unit
    import mips_muldiv_pkg::*;
#(
    parameter int WIDTH = MULDIV_ITER
) (
    input  logic            clock,
    input  logic            reset,
    ex_muldiv_unit_if.slave bus
);
    localparam int                 c_cnt_w    = $clog2(WIDTH);
    localparam logic [c_cnt_w-1:0] c_last_cnt = c_cnt_w'(WIDTH - 1);

    state_t             r_state, w_state_next;
    logic [c_cnt_w-1:0] r_counter;
    logic [WIDTH-1:0]   r_hi, r_lo, r_a_raw;
    logic               r_is_div, r_neg_q, r_neg_r, r_b_zero, r_done;

    logic               w_idle, w_calc, w_accept, w_signed_op, w_div_op, w_a_neg, w_b_neg;
    logic [WIDTH-1:0]   w_mag_a, w_mag_b, w_acc_hi, w_acc_lo, w_fix_hi, w_fix_lo;
    logic [2*WIDTH-1:0] w_prod;

    assign w_idle      = (r_state == S_IDLE);
    assign w_calc      = (r_state == S_CALC);
    assign w_accept    = bus.op_valid && w_idle && is_muldiv(bus.op_code);
    assign w_signed_op = (bus.op_code == OP_MULT) || (bus.op_code == OP_DIV);
    assign w_div_op    = (bus.op_code == OP_DIV) || (bus.op_code == OP_DIVU);
    assign w_a_neg     = w_signed_op && bus.source_a_data[WIDTH-1];
    assign w_b_neg     = w_signed_op && bus.source_b_data[WIDTH-1];
    assign w_mag_a     = w_a_neg ? -bus.source_a_data : bus.source_a_data;
    assign w_mag_b     = w_b_neg ? -bus.source_b_data : bus.source_b_data;

    muldiv_iter_core #(.WIDTH(WIDTH)) u_core (
        .clock    (clock),
        .reset    (reset),
        .load     (w_accept),
        .step     (w_calc),
        .mode_div (r_is_div),
        .mag_a    (w_mag_a),
        .mag_b    (w_mag_b),
        .acc_hi   (w_acc_hi),
        .acc_lo   (w_acc_lo)
    );

    always_ff @(posedge clock) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_next = S_CALC;
            S_CALC:  if (r_counter == c_last_cnt) w_state_next = S_FIX;
            S_FIX:   w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_counter <= '0;
            r_is_div  <= 1'b0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_b_zero  <= 1'b0;
            r_a_raw   <= '0;
        end else if (w_accept) begin
            r_counter <= '0;
            r_is_div  <= w_div_op;
            r_neg_q   <= w_a_neg ^ w_b_neg;
            r_neg_r   <= w_a_neg;
            r_b_zero  <= (bus.source_b_data == '0);
            r_a_raw   <= bus.source_a_data;
        end else if (w_calc) begin
            r_counter <= r_counter + c_cnt_w'(1);
        end
    end

    // Divide by zero bypasses the datapath: LO all ones, HI the raw dividend.
    assign w_prod = {w_acc_hi, w_acc_lo};
    always_comb begin
        w_fix_hi = w_acc_hi;
        w_fix_lo = w_acc_lo;
        if (r_is_div) begin
            if (r_b_zero) begin
                w_fix_hi = r_a_raw;
                w_fix_lo = '1;
            end else begin
                w_fix_hi = r_neg_r ? -w_acc_hi : w_acc_hi;
                w_fix_lo = r_neg_q ? -w_acc_lo : w_acc_lo;
            end
        end else begin
            {w_fix_hi, w_fix_lo} = r_neg_q ? -w_prod : w_prod;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_hi   <= '0;
            r_lo   <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= (r_state == S_FIX);
            if (r_state == S_FIX) begin
                r_hi <= w_fix_hi;
                r_lo <= w_fix_lo;
            end else if (w_idle && bus.op_valid && (bus.op_code == OP_MTHI)) begin
                r_hi <= bus.source_a_data;
            end else if (w_idle && bus.op_valid && (bus.op_code == OP_MTLO)) begin
                r_lo <= bus.source_a_data;
            end
        end
    end

    assign bus.busy       = !w_idle;
    assign bus.stall      = bus.op_valid && !w_idle && is_hilo_op(bus.op_code);
    assign bus.done       = r_done;
    assign bus.hi_lo_data = (bus.op_valid && (bus.op_code == OP_MFHI)) ? r_hi : r_lo;
endmodule
`default_nettype wire
